// File: rtl/alu_if.sv
// alu_if: operand/opcode bus between the controller and the 4-bit ALU.
// Optional build macro: ALU_FLAGS_EN adds the zero/neg/ovf flag signals.
interface alu_if;
  logic       mode;    // 0 = arithmetic bank, 1 = logic bank
  logic [2:0] code;    // operation within the bank
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] result;
  logic       c_out;
`ifdef ALU_FLAGS_EN
  logic       zero;
  logic       neg;
  logic       ovf;

  modport master (
    output mode, code, a, b, c_in,
    input  result, c_out, zero, neg, ovf
  );

  modport slave (
    input  mode, code, a, b, c_in,
    output result, c_out, zero, neg, ovf
  );
`else
  modport master (
    output mode, code, a, b, c_in,
    input  result, c_out
  );

  modport slave (
    input  mode, code, a, b, c_in,
    output result, c_out
  );
`endif
endinterface

// File: rtl/alu.sv
// alu: 4-bit registered ALU, arithmetic and logic banks, one-cycle latency.
// Optional build macro: ALU_FLAGS_EN adds registered zero/neg/ovf flags.
module alu (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  logic [3:0] w_addb;   // second adder operand (b, ~b or a constant)
  logic       w_cin;    // adder carry-in
  logic [4:0] w_sum;
  logic [3:0] w_res;
  logic       w_cout;
  logic [3:0] r_result;
  logic       r_c_out;

  // Select the second operand and carry for the shared 5-bit adder
  always_comb begin
    w_addb = bus.b;
    w_cin  = 1'b0;
    case (bus.code)
      3'b000: begin w_addb = bus.b;   w_cin = 1'b0;      end // ADD
      3'b001: begin w_addb = bus.b;   w_cin = bus.c_in;  end // ADC
      3'b010: begin w_addb = ~bus.b;  w_cin = 1'b1;      end // SUB
      3'b011: begin w_addb = ~bus.b;  w_cin = ~bus.c_in; end // SBB
      3'b100: begin w_addb = 4'b0001; w_cin = 1'b0;      end // INC
      3'b101: begin w_addb = 4'b1111; w_cin = 1'b0;      end // DEC
      default: begin w_addb = bus.b;  w_cin = 1'b0;      end // shifts: unused
    endcase
  end

  assign w_sum = {1'b0, bus.a} + {1'b0, w_addb} + {4'b0000, w_cin};

  // Final result/carry mux across both banks
  always_comb begin
    w_res  = w_sum[3:0];
    w_cout = w_sum[4];
    if (!bus.mode) begin
      case (bus.code)
        3'b110: begin w_res = {bus.a[2:0], bus.c_in}; w_cout = bus.a[3]; end // SHL
        3'b111: begin w_res = {bus.c_in, bus.a[3:1]}; w_cout = bus.a[0]; end // SHR
        default: begin w_res = w_sum[3:0]; w_cout = w_sum[4]; end
      endcase
    end else begin
      w_cout = 1'b0;
      case (bus.code)
        3'b000:  w_res = bus.a & bus.b;
        3'b001:  w_res = bus.a | bus.b;
        3'b010:  w_res = bus.a ^ bus.b;
        3'b011:  w_res = ~bus.a;
        3'b100:  w_res = ~(bus.a & bus.b);
        3'b101:  w_res = ~(bus.a | bus.b);
        3'b110:  w_res = ~(bus.a ^ bus.b);
        default: w_res = bus.b;
      endcase
    end
  end

  // Output register; reset clears it immediately and drops the in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 4'b0000;
      r_c_out  <= 1'b0;
    end else begin
      r_result <= w_res;
      r_c_out  <= w_cout;
    end
  end

  assign bus.result = r_result;
  assign bus.c_out  = r_c_out;

`ifdef ALU_FLAGS_EN
  logic w_is_add;
  logic w_ovf;
  logic r_zero;
  logic r_neg;
  logic r_ovf;

  // Subtraction is folded into addition of ~b / 1111, so one signed-overflow
  // rule (same-sign addends, differently-signed sum) covers all adder ops.
  assign w_is_add = !bus.mode && (bus.code[2:1] != 2'b11);
  assign w_ovf    = w_is_add && (bus.a[3] == w_addb[3]) && (w_res[3] != bus.a[3]);

  // Flag registers load on the same edge as the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_zero <= (w_res == 4'b0000);
      r_neg  <= w_res[3];
      r_ovf  <= w_ovf;
    end
  end

  assign bus.zero = r_zero;
  assign bus.neg  = r_neg;
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for the 4-bit registered ALU.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_if bus();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [2:0] c, input logic [3:0] av,
                       input logic [3:0] bv, input logic ci);
    bus.mode = m;
    bus.code = c;
    bus.a    = av;
    bus.b    = bv;
    bus.c_in = ci;
  endtask

  task automatic test_reset();
    // SUB 6-3 = 0011, c_out 1: nonzero state to be cleared
    drive(1'b0, 3'b010, 4'b0110, 4'b0011, 1'b0);
    step();
    n_tests++;
    if (bus.result !== 4'b0011 || bus.c_out !== 1'b1) begin
      $display("FAIL reset_pre result=%b c_out=%b required 0011/1", bus.result, bus.c_out);
      n_fail++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.result !== 4'b0000 || bus.c_out !== 1'b0) begin
      $display("FAIL reset_async result=%b c_out=%b required 0000/0", bus.result, bus.c_out);
      n_fail++;
    end
`ifdef ALU_FLAGS_EN
    n_tests++;
    if (bus.zero !== 1'b1 || bus.neg !== 1'b0 || bus.ovf !== 1'b0) begin
      $display("FAIL reset_flags z/n/o=%b%b%b required 100", bus.zero, bus.neg, bus.ovf);
      n_fail++;
    end
`endif
    #1;
    rst_n = 1'b1;
    step();
    n_tests++;
    if (bus.result !== 4'b0011 || bus.c_out !== 1'b1) begin
      $display("FAIL reset_first_load result=%b c_out=%b required 0011/1", bus.result, bus.c_out);
      n_fail++;
    end
  endtask

  task automatic test_arith();
    logic [3:0] exp_res [8];
    logic       exp_co  [8];
    exp_res = '{4'b1001, 4'b1001, 4'b0011, 4'b0011, 4'b0111, 4'b0101, 4'b1100, 4'b0011};
    exp_co  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 4'b0110, 4'b0011, 1'b0);
      step();
      n_tests++;
      if (bus.result !== exp_res[i] || bus.c_out !== exp_co[i]) begin
        $display("FAIL arith_code%0d result=%b c_out=%b required %b/%b",
                 i, bus.result, bus.c_out, exp_res[i], exp_co[i]);
        n_fail++;
      end
`ifdef ALU_FLAGS_EN
      if (i == 0) begin
        n_tests++;
        if (bus.ovf !== 1'b1 || bus.neg !== 1'b1 || bus.zero !== 1'b0) begin
          $display("FAIL arith_add_flags z/n/o=%b%b%b required 011", bus.zero, bus.neg, bus.ovf);
          n_fail++;
        end
      end
`endif
    end
  endtask

  task automatic test_logic();
    logic [3:0] exp_res [8];
    exp_res = '{4'b0010, 4'b0111, 4'b0101, 4'b1001, 4'b1101, 4'b1000, 4'b1010, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 4'b0110, 4'b0011, 1'b1);
      step();
      n_tests++;
      if (bus.result !== exp_res[i] || bus.c_out !== 1'b0) begin
        $display("FAIL logic_code%0d result=%b c_out=%b required %b/0",
                 i, bus.result, bus.c_out, exp_res[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_carry_edges();
    // ADC 1111 + 0000 + 1
    drive(1'b0, 3'b001, 4'b1111, 4'b0000, 1'b1);
    step();
    n_tests++;
    if (bus.result !== 4'b0000 || bus.c_out !== 1'b1) begin
      $display("FAIL adc_wrap result=%b c_out=%b required 0000/1", bus.result, bus.c_out);
      n_fail++;
    end
`ifdef ALU_FLAGS_EN
    n_tests++;
    if (bus.zero !== 1'b1) begin
      $display("FAIL adc_wrap_zero zero=%b required 1", bus.zero);
      n_fail++;
    end
`endif
    // SBB 0000 - 0000 - 1
    drive(1'b0, 3'b011, 4'b0000, 4'b0000, 1'b1);
    step();
    n_tests++;
    if (bus.result !== 4'b1111 || bus.c_out !== 1'b0) begin
      $display("FAIL sbb_borrow result=%b c_out=%b required 1111/0", bus.result, bus.c_out);
      n_fail++;
    end
    // DEC 0000
    drive(1'b0, 3'b101, 4'b0000, 4'b1010, 1'b1);
    step();
    n_tests++;
    if (bus.result !== 4'b1111 || bus.c_out !== 1'b0) begin
      $display("FAIL dec_zero result=%b c_out=%b required 1111/0", bus.result, bus.c_out);
      n_fail++;
    end
    // INC 1111 carries out
    drive(1'b0, 3'b100, 4'b1111, 4'b0000, 1'b0);
    step();
    n_tests++;
    if (bus.result !== 4'b0000 || bus.c_out !== 1'b1) begin
      $display("FAIL inc_wrap result=%b c_out=%b required 0000/1", bus.result, bus.c_out);
      n_fail++;
    end
  endtask

  task automatic test_hold();
    // XOR 1111 ^ 0101 = 1010
    drive(1'b1, 3'b010, 4'b1111, 4'b0101, 1'b0);
    step();
    n_tests++;
    if (bus.result !== 4'b1010 || bus.c_out !== 1'b0) begin
      $display("FAIL hold_setup result=%b c_out=%b required 1010/0", bus.result, bus.c_out);
      n_fail++;
    end
    drive(1'b0, 3'b000, 4'b0001, 4'b0001, 1'b0);
    #2;
    drive(1'b1, 3'b011, 4'b0000, 4'b0000, 1'b1);   // NOT 0000 would be 1111
    #1;
    n_tests++;
    if (bus.result !== 4'b1010 || bus.c_out !== 1'b0) begin
      $display("FAIL hold_midcycle result=%b c_out=%b required 1010/0", bus.result, bus.c_out);
      n_fail++;
    end
    drive(1'b0, 3'b000, 4'b0001, 4'b0001, 1'b0);
    step();
    n_tests++;
    if (bus.result !== 4'b0010 || bus.c_out !== 1'b0) begin
      $display("FAIL hold_restored result=%b c_out=%b required 0010/0", bus.result, bus.c_out);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic       v_mode [5];
    logic [2:0] v_code [5];
    logic [3:0] v_a    [5];
    logic [3:0] v_b    [5];
    logic       v_ci   [5];
    logic [3:0] e_res  [5];
    logic       e_co   [5];
    v_mode = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    v_code = '{3'b000, 3'b111, 3'b111, 3'b110, 3'b001};
    v_a    = '{4'h1,   4'h9,   4'h9,   4'h8,   4'h7};
    v_b    = '{4'h2,   4'hC,   4'h0,   4'h0,   4'h1};
    v_ci   = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
    e_res  = '{4'h3,   4'hC,   4'hC,   4'h0,   4'h9};
    e_co   = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(v_mode[i], v_code[i], v_a[i], v_b[i], v_ci[i]);
      step();
      n_tests++;
      if (bus.result !== e_res[i] || bus.c_out !== e_co[i]) begin
        $display("FAIL b2b_op%0d result=%b c_out=%b required %b/%b",
                 i, bus.result, bus.c_out, e_res[i], e_co[i]);
        n_fail++;
      end
    end
`ifdef ALU_FLAGS_EN
    n_tests++;
    if (bus.ovf !== 1'b1 || bus.neg !== 1'b1) begin
      $display("FAIL b2b_adc_ovf ovf=%b neg=%b required 1/1", bus.ovf, bus.neg);
      n_fail++;
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    test_reset();
    test_arith();
    test_logic();
    test_carry_edges();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
